// File: rtl/backward_registered_slice_pkg.sv
// Shared definitions for the valid/ready register slices.
//   slice_state_e : FSM state encoding used by the backward (and forward) slice
//   hs_fire       : a beat transfers on this edge (valid and ready both high)
//   hs_stall      : the producer offers a beat that the consumer refuses this cycle
package backward_registered_slice_pkg;

   typedef enum logic [1:0] {
      RST_HOLD = 2'd0,
      PASS     = 2'd1,
      SKID     = 2'd2
   } slice_state_e;

   function automatic logic hs_fire(input logic vaild, input logic ready);
      return vaild & ready;
   endfunction

   function automatic logic hs_stall(input logic vaild, input logic ready);
      return vaild & ~ready;
   endfunction

endpackage

// File: rtl/backward_registered_slice.sv
// Register slice that breaks the backward (ready) timing path of a valid/ready link.
// src_ready comes straight from a flop; dst side is fed either combinationally from src
// or from a one-entry skid register. Also counts stall cycles on the dst side.
//   clk          : clock, rising edge
//   s_rst        : asynchronous active-high reset
//   src_vaild    : upstream beat valid
//   src_data_in  : upstream beat data
//   src_ready    : registered ready to upstream
//   dst_vaild    : downstream beat valid
//   dst_data_out : downstream beat data
//   dst_ready    : downstream ready
//   skid_full    : skid register holds a beat
//   stat_clr     : synchronous clear of stall_cnt (wins over increment)
//   stall_cnt    : saturating count of cycles with dst_vaild=1 and dst_ready=0
module backward_registered_slice
   import backward_registered_slice_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             src_vaild,
   input  logic [WIDTH-1:0] src_data_in,
   output logic             src_ready,
   output logic             dst_vaild,
   output logic [WIDTH-1:0] dst_data_out,
   input  logic             dst_ready,
   output logic             skid_full,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   slice_state_e     state_q, state_d;
   logic             src_ready_q;
   logic             skid_full_q;
   logic [WIDTH-1:0] skid_data_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             capture;

   // A beat accepted in PASS that dst refuses must be parked, or it is lost.
   assign capture = (state_q == PASS) && hs_fire(src_vaild, src_ready_q) && !dst_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RST_HOLD: state_d = PASS;
         PASS:     if (capture) state_d = SKID;
         SKID:     if (dst_ready) state_d = PASS;
         default:  state_d = RST_HOLD;
      endcase
   end

   // State and all upstream-facing outputs registered together; src_ready never
   // depends combinationally on dst_ready.
   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         state_q     <= RST_HOLD;
         src_ready_q <= 1'b0;
         skid_full_q <= 1'b0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         src_ready_q <= (state_d == PASS);
         skid_full_q <= (state_d == SKID);
         if (capture) begin
            skid_data_q <= src_data_in;
         end
      end
   end

   // RST_HOLD blocks dst: upstream has not been told ready yet, so passing a beat
   // through would deliver something never accepted.
   always_comb begin
      dst_vaild    = 1'b0;
      dst_data_out = src_data_in;
      unique case (state_q)
         PASS: dst_vaild = src_vaild;
         SKID: begin
            dst_vaild    = 1'b1;
            dst_data_out = skid_data_q;
         end
         default: dst_vaild = 1'b0;
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stat_clr) begin
         stall_cnt_d = '0;
      end else if (hs_stall(dst_vaild, dst_ready) && (stall_cnt_q != CntMax)) begin
         stall_cnt_d = stall_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk or posedge s_rst) begin
      if (s_rst) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign src_ready = src_ready_q;
   assign skid_full = skid_full_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_backward_registered_slice.sv
module tb_backward_registered_slice;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             s_rst;
   logic             src_vaild;
   logic [WIDTH-1:0] src_data_in;
   logic             src_ready;
   logic             dst_vaild;
   logic [WIDTH-1:0] dst_data_out;
   logic             dst_ready;
   logic             skid_full;
   logic             stat_clr;
   logic [CNT_W-1:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [WIDTH-1:0] sb_q[$];

   always #5 clk = ~clk;

   backward_registered_slice #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_dut (
      .clk          (clk),
      .s_rst        (s_rst),
      .src_vaild    (src_vaild),
      .src_data_in  (src_data_in),
      .src_ready    (src_ready),
      .dst_vaild    (dst_vaild),
      .dst_data_out (dst_data_out),
      .dst_ready    (dst_ready),
      .skid_full    (skid_full),
      .stat_clr     (stat_clr),
      .stall_cnt    (stall_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: mid-cycle sample of both handshakes that fire at the next edge.
   always @(negedge clk) begin
      logic [WIDTH-1:0] exp_beat;
      if (s_rst) begin
         sb_q.delete();
      end else begin
         if (src_vaild && src_ready) sb_q.push_back(src_data_in);
         if (dst_vaild && dst_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got %0h required no beat", dst_data_out);
            end else begin
               exp_beat = sb_q.pop_front();
               if (dst_data_out !== exp_beat) begin
                  n_fail++;
                  $display("FAIL sb_order: got %0h required %0h", dst_data_out, exp_beat);
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   beats;
      int   cycles;
      logic acc;
      logic prev_rdy;

      s_rst       = 1'b1;
      src_vaild   = 1'b0;
      src_data_in = '0;
      dst_ready   = 1'b1;
      stat_clr    = 1'b0;

      // Reset state and release sequence
      cyc();
      cyc();
      chk("rst_src_ready", src_ready, 0);
      chk("rst_skid_full", skid_full, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_dst_vaild", dst_vaild, 0);
      s_rst = 1'b0;
      #1;
      chk("rel_first_cycle_rdy", src_ready, 0);
      cyc();
      #1;
      chk("rel_second_cycle_rdy", src_ready, 1);
      chk("rel_stall_cnt", stall_cnt, 0);

      // Back-to-back streaming, zero latency
      for (int i = 1; i <= 16; i++) begin
         cyc();
         src_vaild   = 1'b1;
         src_data_in = 8'(i);
         #1;
         chk("stream_dst_vaild", dst_vaild, 1);
         chk("stream_dst_data", dst_data_out, i);
         chk("stream_src_ready", src_ready, 1);
         chk("stream_skid_full", skid_full, 0);
      end
      cyc();
      src_vaild = 1'b0;

      // Skid capture of 0xA5; clear the counter in the capture cycle so only SKID stalls count
      cyc();
      src_vaild   = 1'b1;
      src_data_in = 8'hA5;
      dst_ready   = 1'b0;
      stat_clr    = 1'b1;
      #1;
      chk("skid_pass_through", dst_data_out, 8'hA5);
      cyc();
      src_vaild   = 1'b0;
      src_data_in = 8'h00;
      stat_clr    = 1'b0;
      #1;
      chk("skid_full_set", skid_full, 1);
      chk("skid_src_ready_low", src_ready, 0);
      chk("skid_stall_start", stall_cnt, 0);
      chk("skid_data_c1", dst_data_out, 8'hA5);
      for (int k = 1; k <= 3; k++) begin
         cyc();
         #1;
         chk("skid_stall_cnt", stall_cnt, k);
         chk("skid_data_held", dst_data_out, 8'hA5);
         chk("skid_dst_vaild", dst_vaild, 1);
         chk("skid_src_ready_hold", src_ready, 0);
      end
      dst_ready = 1'b1;
      cyc();
      #1;
      chk("drain_src_ready_back", src_ready, 1);
      chk("drain_skid_clear", skid_full, 0);
      chk("drain_dst_idle", dst_vaild, 0);
      chk("drain_once", sb_q.size(), 0);

      // Counter saturation at 15 and clear priority
      cyc();
      src_vaild   = 1'b1;
      src_data_in = 8'h5A;
      dst_ready   = 1'b0;
      stat_clr    = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (k == 0) begin
            src_vaild   = 1'b0;
            src_data_in = 8'h00;
            stat_clr    = 1'b0;
         end
         #1;
         chk("sat_stall_cnt", stall_cnt, (k > 15) ? 15 : k);
      end
      stat_clr = 1'b1;
      cyc();
      stat_clr  = 1'b0;
      dst_ready = 1'b1;
      #1;
      chk("clr_priority", stall_cnt, 0);
      chk("clr_skid_data", dst_data_out, 8'h5A);
      cyc();
      #1;
      chk("clr_drained", sb_q.size(), 0);

      // Random back-pressure
      beats  = 0;
      cycles = 0;
      acc    = 1'b0;
      while (beats < 1000 && cycles < 20000) begin
         cyc();
         cycles++;
         prev_rdy = src_ready;
         if (!src_vaild || acc) begin
            src_vaild   = 1'($urandom);
            src_data_in = 8'($urandom);
         end
         dst_ready = 1'($urandom);
         #1;
         chk("rdy_no_comb", src_ready, prev_rdy);
         acc = src_vaild & src_ready;
         if (acc) beats++;
      end
      chk("rand_beats", beats, 1000);
      cyc();
      src_vaild = 1'b0;
      dst_ready = 1'b1;
      repeat (3) cyc();
      #1;
      chk("rand_drain", sb_q.size(), 0);

      // Async reset while SKID holds 0x3C
      cyc();
      src_vaild   = 1'b1;
      src_data_in = 8'h3C;
      dst_ready   = 1'b0;
      cyc();
      src_vaild   = 1'b0;
      src_data_in = 8'h00;
      #1;
      chk("rst_skid_full_pre", skid_full, 1);
      chk("rst_skid_data_pre", dst_data_out, 8'h3C);
      #1;
      s_rst = 1'b1;
      #1;
      chk("async_src_ready", src_ready, 0);
      chk("async_skid_full", skid_full, 0);
      chk("async_dst_vaild", dst_vaild, 0);
      cyc();
      cyc();
      s_rst     = 1'b0;
      dst_ready = 1'b1;
      #1;
      chk("rerel_first_rdy", src_ready, 0);
      cyc();
      #1;
      chk("rerel_second_rdy", src_ready, 1);
      chk("rerel_no_stale", dst_vaild, 0);
      repeat (3) cyc();
      src_vaild   = 1'b1;
      src_data_in = 8'h77;
      #1;
      chk("rerel_new_beat", dst_data_out, 8'h77);
      cyc();
      src_vaild = 1'b0;
      repeat (2) cyc();
      #1;
      chk("rerel_sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
